nn_decision_stage: RTL and testbench
====================================

Name: nn_decision_stage

Overview:
- Downstream consumer of the hidden/output-layer block. Takes the N_CLASS output-neuron scores of one inference frame through a valid/ready handshake.
- Finds the winning class with a sequential argmax, one comparison per cycle, and grades confidence against the runner-up.
- Counts consecutive confident drowsy frames and drives a held, clearable drowsiness alarm.

Parameters:
- W, 10, score width (unsigned).
- N_CLASS, 3, number of output-neuron scores per frame (>=2).
- DROWSY_CLASS, 2, class index meaning "drowsy".
- MARGIN, 8, minimum best-minus-runner-up difference for a confident decision.
- ALARM_FRAMES, 4, consecutive confident drowsy decisions needed to raise the alarm.
- HOLD_CYCLES, 16, clock cycles the alarm stays high after the drowsy streak breaks.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Rst  in  1  asynchronous active-low reset.
- in_valid  in  1  score frame valid.
- score  in  W x [0:N_CLASS-1]  unpacked array of output-neuron scores.
- in_ready  out  1  block can accept a frame.
- class_id  out  clog2(N_CLASS)  winning class index.
- class_valid  out  1  one-cycle strobe, class_id/confident updated.
- confident  out  1  (best - runner_up) >= MARGIN.
- drowsy_count  out  clog2(ALARM_FRAMES+1)  current consecutive confident drowsy count.
- alarm_clr  in  1  synchronous alarm acknowledge/clear.
- alarm  out  1  drowsiness alarm.

Behaviour:
- Reset (Rst=0, asynchronous, any state):
  - FSM goes to IDLE.
  - in_ready=1; class_id=0, class_valid=0, confident=0, drowsy_count=0, alarm=0.
  - Hold timer, best, runner_up and index registers all 0.
  - Any in-flight frame is discarded, with no class_valid for it.
- FSM states: IDLE, COMPARE, DECIDE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, the frame is accepted: all scores are latched, best=score[0], runner_up=0, best_idx=0, cmp_idx=1. Next state is COMPARE.
  - in_valid=0 stays in IDLE.
- COMPARE:
  - in_ready=0. Per edge, compare the latched score[cmp_idx]:
    - if score > best: runner_up=best, best=score, best_idx=cmp_idx;
    - else if score > runner_up: runner_up=score.
  - Then cmp_idx++. After cmp_idx==N_CLASS-1 is processed, go to DECIDE.
  - Strict comparison, so ties resolve to the lowest index.
  - Scores are unsigned. The difference best - runner_up is computed at W bits, cannot underflow, and never wraps.
- DECIDE:
  - in_ready=0. One edge: class_id=best_idx, confident=(best-runner_up>=MARGIN), class_valid=1 for exactly the following cycle. Update the streak logic (below). Next state is IDLE.
- Latency: frame accepted at edge k gives class_valid high in the cycle after edge k+N_CLASS. in_ready is high again after the same edge, so the next frame can be accepted at edge k+N_CLASS+1 (throughput of 1 frame per N_CLASS+1 cycles).
- in_valid while in_ready=0 is ignored. Upstream holds the frame; score changes while busy have no effect (scores are latched).
- Streak logic, evaluated at the DECIDE edge:
  - drowsy = (best_idx==DROWSY_CLASS) && confident.
  - drowsy=1: drowsy_count increments, saturating at ALARM_FRAMES. When drowsy_count becomes ALARM_FRAMES, alarm=1 and the hold timer is cleared.
  - drowsy=0: drowsy_count=0. If alarm=1, the hold timer is loaded with HOLD_CYCLES.
- Hold timer:
  - Nonzero and alarm=1: decrements each edge. The edge where it reaches 0 clears alarm.
  - A new drowsy decision during hold increments drowsy_count from 0 and does not cancel the running hold. Alarm stays up only if the count re-reaches ALARM_FRAMES before the timer expires; that clears the timer.
- alarm_clr=1 at an edge: alarm=0, hold timer=0, drowsy_count=0.
  - Has priority over a simultaneous DECIDE streak update. That frame's class_id/confident/class_valid still update; its drowsy contribution is dropped.
  - Does not affect the FSM or in_ready.
- No combinational path from in_valid to in_ready. All outputs are registered.

Test Plan:
- Reset mid-COMPARE: accept {100,300,200}, drop Rst one edge later → in_ready=1 and all outputs 0 immediately (asynchronous); no class_valid afterwards.
- Basic argmax: score={100,300,200}, in_valid pulse at edge k → class_valid only in the cycle after edge k+3, class_id=1, confident=1 (300-200=100>=8); in_ready low for edges k+1..k+3.
- Tie/margin: {500,500,10} → class_id=0, confident=0. Then {0,0,1023} → class_id=2, confident=1. Then {0,5,10} → class_id=2, confident=0 (10-5<8), drowsy_count=0.
- Alarm raise and hold: four frames {0,0,900} → drowsy_count=1,2,3,4; alarm rises at the 4th DECIDE edge. A fifth drowsy frame keeps drowsy_count=4 (saturated). Frame {900,0,0} → drowsy_count=0; alarm stays high exactly 16 more cycles, then falls.
- Clear priority: at drowsy_count=3, assert alarm_clr on the DECIDE edge of a 4th {0,0,900} frame → class_valid=1, class_id=2, drowsy_count=0, alarm=0.
- Backpressure: hold in_valid=1 with changing scores continuously → frames accepted every 4 edges; each decision matches the scores present at its accept edge.

Source files
------------

// File: rtl/nn_decision_stage_if.sv
// Score-frame handshake between the output-layer block (master) and the
// decision stage (slave).
interface nn_decision_stage_if #(
  parameter int unsigned W       = 10,
  parameter int unsigned N_CLASS = 3
);
  logic         in_valid;
  logic [W-1:0] score [0:N_CLASS-1];
  logic         in_ready;

  modport master (output in_valid, output score, input in_ready);
  modport slave  (input in_valid, input score, output in_ready);
endinterface

// File: rtl/nn_decision_stage.sv
// Sequential argmax over one frame of output-neuron scores, confidence grading
// against the runner-up, and a held, clearable drowsiness alarm.
module nn_decision_stage #(
  parameter int unsigned W            = 10,
  parameter int unsigned N_CLASS      = 3,
  parameter int unsigned DROWSY_CLASS = 2,
  parameter int unsigned MARGIN       = 8,
  parameter int unsigned ALARM_FRAMES = 4,
  parameter int unsigned HOLD_CYCLES  = 16,
  localparam int unsigned IdxW  = $clog2(N_CLASS),
  localparam int unsigned CntW  = $clog2(ALARM_FRAMES + 1),
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1)
) (
  input  logic                Clock,
  input  logic                Rst,
  nn_decision_stage_if.slave  frame,
  input  logic                alarm_clr,
  output logic [IdxW-1:0]     class_id,
  output logic                class_valid,
  output logic                confident,
  output logic [CntW-1:0]     drowsy_count,
  output logic                alarm
);

  typedef enum logic [1:0] {StIdle, StCompare, StDecide} state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      scores_q [N_CLASS];
  logic [W-1:0]      scores_d [N_CLASS];
  logic [W-1:0]      best_q, best_d, runner_q, runner_d;
  logic [IdxW-1:0]   best_idx_q, best_idx_d, cmp_idx_q, cmp_idx_d;
  logic [IdxW-1:0]   class_id_q, class_id_d;
  logic              class_valid_q, class_valid_d, confident_q, confident_d;
  logic              in_ready_q, in_ready_d, alarm_q, alarm_d;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [W-1:0]      cur_score, diff;
  logic              conf_now, drowsy;

  always_comb begin
    cur_score = '0;
    for (int i = 0; i < N_CLASS; i++) begin
      if (cmp_idx_q == IdxW'(i)) cur_score = scores_q[i];
    end
  end

  // best >= runner_up always holds, so the W-bit difference never wraps.
  assign diff     = best_q - runner_q;
  assign conf_now = (diff >= W'(MARGIN));
  assign drowsy   = (best_idx_q == IdxW'(DROWSY_CLASS)) && conf_now;
  assign cnt_inc  = (cnt_q == CntW'(ALARM_FRAMES)) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    scores_d      = scores_q;
    best_d        = best_q;
    runner_d      = runner_q;
    best_idx_d    = best_idx_q;
    cmp_idx_d     = cmp_idx_q;
    class_id_d    = class_id_q;
    confident_d   = confident_q;
    class_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame.in_valid) begin
          for (int i = 0; i < N_CLASS; i++) scores_d[i] = frame.score[i];
          best_d     = frame.score[0];
          runner_d   = '0;
          best_idx_d = '0;
          cmp_idx_d  = IdxW'(1);
          state_d    = StCompare;
        end
      end
      StCompare: begin
        if (cur_score > best_q) begin
          runner_d   = best_q;
          best_d     = cur_score;
          best_idx_d = cmp_idx_q;
        end else if (cur_score > runner_q) begin
          runner_d = cur_score;
        end
        cmp_idx_d = cmp_idx_q + 1'b1;
        if (cmp_idx_q == IdxW'(N_CLASS - 1)) state_d = StDecide;
      end
      StDecide: begin
        class_id_d    = best_idx_q;
        confident_d   = conf_now;
        class_valid_d = 1'b1;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
    in_ready_d = (state_d == StIdle);
  end

  // Streak / hold-timer / alarm next state; the clear acknowledge wins last.
  always_comb begin
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    alarm_d = alarm_q;
    if (alarm_q && (hold_q != '0)) begin
      hold_d = hold_q - 1'b1;
      if (hold_q == HoldW'(1)) alarm_d = 1'b0;
    end
    if (state_q == StDecide) begin
      if (drowsy) begin
        cnt_d = cnt_inc;
        if (cnt_inc == CntW'(ALARM_FRAMES)) begin
          alarm_d = 1'b1;
          hold_d  = '0;
        end
      end else begin
        cnt_d = '0;
        if (alarm_q) begin
          hold_d  = HoldW'(HOLD_CYCLES);
          alarm_d = 1'b1;
        end
      end
    end
    if (alarm_clr) begin
      cnt_d   = '0;
      hold_d  = '0;
      alarm_d = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      state_q       <= StIdle;
      for (int i = 0; i < N_CLASS; i++) scores_q[i] <= '0;
      best_q        <= '0;
      runner_q      <= '0;
      best_idx_q    <= '0;
      cmp_idx_q     <= '0;
      class_id_q    <= '0;
      class_valid_q <= 1'b0;
      confident_q   <= 1'b0;
      in_ready_q    <= 1'b1;
      cnt_q         <= '0;
      hold_q        <= '0;
      alarm_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      scores_q      <= scores_d;
      best_q        <= best_d;
      runner_q      <= runner_d;
      best_idx_q    <= best_idx_d;
      cmp_idx_q     <= cmp_idx_d;
      class_id_q    <= class_id_d;
      class_valid_q <= class_valid_d;
      confident_q   <= confident_d;
      in_ready_q    <= in_ready_d;
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      alarm_q       <= alarm_d;
    end
  end

  assign frame.in_ready = in_ready_q;
  assign class_id       = class_id_q;
  assign class_valid    = class_valid_q;
  assign confident      = confident_q;
  assign drowsy_count   = cnt_q;
  assign alarm          = alarm_q;

endmodule

// File: tb/tb_nn_decision_stage.sv
// Self-checking bench for nn_decision_stage: directed scenarios plus a
// randomized back-to-back run against a frame-level argmax/streak model.
module tb_nn_decision_stage;
  localparam int unsigned W    = 10;
  localparam int unsigned N    = 3;
  localparam int unsigned IdxW = 2;
  localparam int unsigned CntW = 3;

  typedef logic [W-1:0] frame_t [N];
  typedef struct {
    logic [IdxW-1:0] id;
    logic            conf;
    logic [CntW-1:0] cnt;
  } exp_t;

  logic            Clock = 1'b0;
  logic            Rst;
  logic            alarm_clr;
  logic [IdxW-1:0] class_id;
  logic            class_valid;
  logic            confident;
  logic [CntW-1:0] drowsy_count;
  logic            alarm;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  nn_decision_stage_if #(.W(W), .N_CLASS(N)) frame ();

  nn_decision_stage #(
    .W(W), .N_CLASS(N), .DROWSY_CLASS(2), .MARGIN(8), .ALARM_FRAMES(4), .HOLD_CYCLES(16)
  ) dut (
    .Clock(Clock),
    .Rst(Rst),
    .frame(frame),
    .alarm_clr(alarm_clr),
    .class_id(class_id),
    .class_valid(class_valid),
    .confident(confident),
    .drowsy_count(drowsy_count),
    .alarm(alarm)
  );

  // Reference: first index holding the maximum; runner-up is the largest other score.
  function automatic void ref_decide(input frame_t s, output int id, output bit conf);
    int run;
    id = 0;
    for (int i = 1; i < N; i++) if (s[i] > s[id]) id = i;
    run = 0;
    for (int j = 0; j < N; j++) if (j != id && int'(s[j]) > run) run = int'(s[j]);
    conf = (int'(s[id]) - run) >= 8;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    int mode = $urandom_range(0, 3);
    for (int i = 0; i < N; i++) begin
      if (mode == 0) f[i] = W'($urandom_range(0, 12));
      else           f[i] = W'($urandom_range(0, 1023));
    end
    if (mode == 1) f[2] = W'($urandom_range(900, 1023));
    return f;
  endfunction

  task automatic drive_scores(input frame_t s);
    for (int i = 0; i < N; i++) frame.score[i] = s[i];
  endtask

  // Sends one frame (caller sits #1 after an edge) and samples the decision cycle.
  task automatic run_frame(input frame_t s, input bit clr,
                           output logic [IdxW-1:0] o_id, output logic o_conf,
                           output logic [CntW-1:0] o_cnt, output logic o_alarm,
                           output logic o_cv, output bit o_timing);
    int t = 0;
    while (frame.in_ready !== 1'b1 && t < 20) begin
      @(posedge Clock); #1; t++;
    end
    if (t == 20) begin
      checks++; errors++;
      $display("FAIL ready_timeout in_ready=%b required 1", frame.in_ready);
    end
    frame.in_valid = 1'b1;
    drive_scores(s);
    @(posedge Clock); #1;
    frame.in_valid = 1'b0;
    drive_scores(rand_frame());
    o_timing = (frame.in_ready === 1'b0) && (class_valid === 1'b0);
    repeat (N - 1) begin
      @(posedge Clock); #1;
      if (frame.in_ready !== 1'b0 || class_valid !== 1'b0) o_timing = 0;
    end
    alarm_clr = clr;
    @(posedge Clock); #1;
    alarm_clr = 1'b0;
    if (frame.in_ready !== 1'b1) o_timing = 0;
    o_id = class_id; o_conf = confident; o_cnt = drowsy_count;
    o_alarm = alarm; o_cv = class_valid;
  endtask

  task automatic test_reset();
    Rst = 1'b0; alarm_clr = 1'b0; frame.in_valid = 1'b0;
    drive_scores('{default: '0});
    repeat (2) @(posedge Clock);
    #1;
    checks++; if (frame.in_ready !== 1'b1) begin errors++;
      $display("FAIL rst_in_ready got %b exp 1", frame.in_ready); end
    checks++; if (class_valid !== 1'b0) begin errors++;
      $display("FAIL rst_class_valid got %b exp 0", class_valid); end
    checks++; if (class_id !== '0) begin errors++;
      $display("FAIL rst_class_id got %0d exp 0", class_id); end
    checks++; if (confident !== 1'b0) begin errors++;
      $display("FAIL rst_confident got %b exp 0", confident); end
    checks++; if (drowsy_count !== '0 || alarm !== 1'b0) begin errors++;
      $display("FAIL rst_streak got cnt=%0d alarm=%b exp 0/0", drowsy_count, alarm); end
    @(negedge Clock); Rst = 1'b1;
    @(posedge Clock); #1;
  endtask

  task automatic test_basic();
    logic [IdxW-1:0] id; logic cf, al, cv; logic [CntW-1:0] cn; bit tm;
    int eid; bit ecf;
    frame_t f = '{10'd100, 10'd300, 10'd200};
    ref_decide(f, eid, ecf);
    run_frame(f, 1'b0, id, cf, cn, al, cv, tm);
    checks++; if (cv !== 1'b1 || tm !== 1'b1) begin errors++;
      $display("FAIL basic_timing got cv=%b timing=%b exp 1/1", cv, tm); end
    checks++; if (id !== IdxW'(eid) || eid != 1) begin errors++;
      $display("FAIL basic_id got %0d exp 1", id); end
    checks++; if (cf !== ecf || !ecf) begin errors++;
      $display("FAIL basic_conf got %b exp 1", cf); end
    checks++; if (cn !== '0 || al !== 1'b0) begin errors++;
      $display("FAIL basic_streak got cnt=%0d alarm=%b exp 0/0", cn, al); end
    @(posedge Clock); #1;
    checks++; if (class_valid !== 1'b0) begin errors++;
      $display("FAIL basic_strobe_len got %b exp 0", class_valid); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    frame.in_valid = 1'b1;
    drive_scores('{10'd100, 10'd300, 10'd200});
    @(posedge Clock); #1;
    frame.in_valid = 1'b0;
    @(posedge Clock); #2;
    Rst = 1'b0;
    #1;
    checks++; if (frame.in_ready !== 1'b1) begin errors++;
      $display("FAIL midrst_in_ready got %b exp 1", frame.in_ready); end
    checks++; if (class_id !== '0 || confident !== 1'b0 || class_valid !== 1'b0) begin errors++;
      $display("FAIL midrst_outputs got id=%0d conf=%b cv=%b exp 0/0/0",
               class_id, confident, class_valid); end
    @(negedge Clock); Rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge Clock); #1;
      if (class_valid === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++;
      $display("FAIL midrst_no_strobe got %0d strobes exp 0", seen); end
  endtask

  task automatic test_tie_margin();
    logic [IdxW-1:0] id; logic cf, al, cv; logic [CntW-1:0] cn; bit tm;
    frame_t fr [3] = '{'{10'd500, 10'd500, 10'd10}, '{10'd0, 10'd0, 10'd1023},
                       '{10'd0, 10'd5, 10'd10}};
    logic [IdxW-1:0] eid [3] = '{2'd0, 2'd2, 2'd2};
    logic            ecf [3] = '{1'b0, 1'b1, 1'b0};
    logic [CntW-1:0] ecn [3] = '{3'd0, 3'd1, 3'd0};
    for (int k = 0; k < 3; k++) begin
      run_frame(fr[k], 1'b0, id, cf, cn, al, cv, tm);
      checks++; if (id !== eid[k] || cv !== 1'b1) begin errors++;
        $display("FAIL tie_id[%0d] got %0d cv=%b exp %0d", k, id, cv, eid[k]); end
      checks++; if (cf !== ecf[k]) begin errors++;
        $display("FAIL tie_conf[%0d] got %b exp %b", k, cf, ecf[k]); end
      checks++; if (cn !== ecn[k]) begin errors++;
        $display("FAIL tie_cnt[%0d] got %0d exp %0d", k, cn, ecn[k]); end
    end
  endtask

  task automatic test_alarm();
    logic [IdxW-1:0] id; logic cf, al, cv; logic [CntW-1:0] cn; bit tm;
    int fall = 0;
    frame_t dz = '{10'd0, 10'd0, 10'd900};
    frame_t aw = '{10'd900, 10'd0, 10'd0};
    for (int k = 1; k <= 5; k++) begin
      run_frame(dz, 1'b0, id, cf, cn, al, cv, tm);
      checks++; if (cn !== CntW'(k > 4 ? 4 : k)) begin errors++;
        $display("FAIL alarm_cnt[%0d] got %0d exp %0d", k, cn, k > 4 ? 4 : k); end
      checks++; if (al !== (k >= 4)) begin errors++;
        $display("FAIL alarm_level[%0d] got %b exp %b", k, al, k >= 4); end
    end
    run_frame(aw, 1'b0, id, cf, cn, al, cv, tm);
    checks++; if (cn !== '0 || al !== 1'b1 || id !== '0) begin errors++;
      $display("FAIL alarm_break got cnt=%0d alarm=%b id=%0d exp 0/1/0", cn, al, id); end
    for (int c = 1; c <= 24; c++) begin
      @(posedge Clock); #1;
      if (alarm === 1'b0 && fall == 0) fall = c;
    end
    checks++; if (fall != 16) begin errors++;
      $display("FAIL alarm_hold got fall at %0d exp 16", fall); end
  endtask

  task automatic test_clear();
    logic [IdxW-1:0] id; logic cf, al, cv; logic [CntW-1:0] cn; bit tm;
    frame_t dz = '{10'd0, 10'd0, 10'd900};
    for (int k = 0; k < 3; k++) run_frame(dz, 1'b0, id, cf, cn, al, cv, tm);
    checks++; if (cn !== 3'd3) begin errors++;
      $display("FAIL clear_pre_cnt got %0d exp 3", cn); end
    run_frame(dz, 1'b1, id, cf, cn, al, cv, tm);
    checks++; if (cv !== 1'b1 || id !== 2'd2) begin errors++;
      $display("FAIL clear_decision got cv=%b id=%0d exp 1/2", cv, id); end
    checks++; if (cn !== '0 || al !== 1'b0) begin errors++;
      $display("FAIL clear_streak got cnt=%0d alarm=%b exp 0/0", cn, al); end
  endtask

  task automatic test_back_to_back();
    exp_t q[$];
    exp_t e;
    frame_t f;
    int last_acc = -1, nacc = 0, ndec = 0, cnt_model = 0, eid;
    bit ecf, stop = 0;
    frame.in_valid = 1'b1;
    f = rand_frame();
    drive_scores(f);
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!stop && frame.in_ready === 1'b1) begin
        ref_decide(f, eid, ecf);
        cnt_model = (eid == 2 && ecf) ? (cnt_model < 4 ? cnt_model + 1 : 4) : 0;
        e.id = IdxW'(eid); e.conf = ecf; e.cnt = CntW'(cnt_model);
        q.push_back(e);
        if (last_acc >= 0) begin
          checks++; if (cyc - last_acc != 4) begin errors++;
            $display("FAIL b2b_interval got %0d exp 4", cyc - last_acc); end
        end
        last_acc = cyc;
        nacc++;
        if (nacc == 40) stop = 1;
      end
      @(posedge Clock); #1;
      if (stop) frame.in_valid = 1'b0;
      if (class_valid === 1'b1) begin
        ndec++;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL b2b_spurious got class_valid=1 exp 0");
        end else begin
          e = q.pop_front();
          checks++; if (class_id !== e.id || confident !== e.conf) begin errors++;
            $display("FAIL b2b_decision got id=%0d conf=%b exp %0d/%b",
                     class_id, confident, e.id, e.conf); end
          checks++; if (drowsy_count !== e.cnt) begin errors++;
            $display("FAIL b2b_cnt got %0d exp %0d", drowsy_count, e.cnt); end
        end
      end
      f = rand_frame();
      drive_scores(f);
      if (stop && q.size() == 0) break;
    end
    checks++; if (ndec != 40) begin errors++;
      $display("FAIL b2b_count got %0d decisions exp 40", ndec); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mid();
    test_tie_margin();
    test_alarm();
    test_clear();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
